// File: rtl/hbm_back_packer.sv
// rtl/hbm_back_packer.sv - packs 32-bit result words into 512-bit send-back lines
module hbm_back_packer #(
    parameter int WORD_W = 32,
    parameter int LINE_W = 512
) (
    input  logic              hbm_clk,
    input  logic              hbm_aresetn,
    input  logic              start,
    input  logic [31:0]       word_count,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              almost_full,
    output logic [LINE_W-1:0] back_data,
    output logic              back_valid,
    output logic [31:0]       byte_length,
    output logic              busy,
    output logic              done
);

    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int IDX_W          = $clog2(WORDS_PER_LINE);
    localparam int LINE_BYTES_LG  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        remaining;
    logic [LINE_W-1:0]  line_reg;
    logic [LINE_W-1:0]  line_next;
    logic [31:0]        line_cnt;
    logic               accept;
    logic               last_word;
    logic               emit;

    // Words flow only while packing and the send-back FIFO has room.
    assign s_ready   = (state == ST_PACK) && !almost_full;
    assign accept    = s_valid && s_ready;
    assign last_word = (remaining == 32'd1);
    assign emit      = accept && ((word_idx == IDX_W'(WORDS_PER_LINE - 1)) || last_word);
    assign line_cnt  = (word_count + 32'(WORDS_PER_LINE - 1)) >> IDX_W;

    // Current line with the incoming word merged into its slot.
    always_comb begin
        line_next = line_reg;
        line_next[word_idx*WORD_W +: WORD_W] = s_data;
    end

    // Job FSM, slot filling and line emission.
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            state       <= ST_IDLE;
            word_idx    <= '0;
            remaining   <= '0;
            line_reg    <= '0;
            back_data   <= '0;
            back_valid  <= 1'b0;
            byte_length <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            back_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining   <= word_count;
                        byte_length <= line_cnt << LINE_BYTES_LG;
                        word_idx    <= '0;
                        line_reg    <= '0;
                        busy        <= 1'b1;
                        state       <= (word_count == 32'd0) ? ST_DONE : ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (accept) begin
                        remaining <= remaining - 32'd1;
                        word_idx  <= word_idx + 1'b1;
                        if (emit) begin
                            back_data  <= line_next;
                            back_valid <= 1'b1;
                            line_reg   <= '0;
                        end else begin
                            line_reg <= line_next;
                        end
                        if (last_word) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
